// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// granting bursts of up to BURST words and stalling while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      fifo_full,
    output logic                      fifo_write,
    output logic [WIDTH-1:0]          fifo_data_in,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state;
    logic [OW-1:0]  last;
    logic [BW-1:0]  bcnt;

    logic [OW-1:0]  pick;
    logic [OW-1:0]  cand;
    logic           found;
    int unsigned    idx;

    // Search starts just past the previous owner so a releasing owner is served last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx  = (32'(last) + i) % NREQ;
            cand = OW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        busy         = (state == OWN);
        fifo_write   = 1'b0;
        fifo_data_in = '0;
        ack          = '0;
        if (state == OWN) begin
            fifo_write   = req[owner] & ~fifo_full;
            fifo_data_in = req_data[owner*WIDTH +: WIDTH];
            ack          = fifo_write ? (NREQ'(1) << owner) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            owner <= '0;
            last  <= OW'(NREQ - 1);
            bcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= pick;
                        bcnt  <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    // Withdrawal takes priority over a full stall.
                    if (!req[owner]) begin
                        state <= IDLE;
                        last  <= owner;
                    end else if (!fifo_full) begin
                        if (bcnt == BW'(BURST - 1)) begin
                            state <= IDLE;
                            last  <= owner;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, bursts, rotation, full stall,
// withdrawal and asynchronous reset in the middle of a grant.
module tb_fifo_wr_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned BURST = 4;

    logic                    clk;
    logic                    rst_;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         ack;
    logic                    fifo_full;
    logic                    fifo_write;
    logic [WIDTH-1:0]        fifo_data_in;
    logic [1:0]              owner;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_write   (fifo_write),
        .fifo_data_in (fifo_data_in),
        .owner        (owner),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] dword(int i, int k);
        return WIDTH'(16'hA000 + i * 16'h0100 + k);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(int i, logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic drain();
        req = '0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        #2;
        if (fifo_write !== 1'b0) begin $display("FAIL rst_write: got %b want 0", fifo_write); errors++; end
        checks++;
        if (ack !== 4'b0000) begin $display("FAIL rst_ack: got %b want 0000", ack); errors++; end
        checks++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); errors++; end
        checks++;
        if (owner !== 2'd0) begin $display("FAIL rst_owner: got %0d want 0", owner); errors++; end
        checks++;
        cyc();
        rst_ = 1'b1;
        #1;
        if (busy !== 1'b0) begin $display("FAIL rst_rel_idle: busy got %b want 0", busy); errors++; end
        checks++;
        cyc();
        #1;
        if (busy !== 1'b1 || owner !== 2'd0) begin
            $display("FAIL rst_first_grant: busy=%b owner=%0d want 1/0", busy, owner); errors++;
        end
        checks++;
        if (ack !== 4'b0001) begin $display("FAIL rst_first_ack: got %b want 0001", ack); errors++; end
        checks++;
        drain();
    endtask

    task automatic test_single_burst();
        int k;
        logic exp_ack [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) cyc();
            req = (k < 6) ? 4'b0100 : 4'b0000;
            set_data(2, dword(2, k));
            #1;
            if (ack !== (exp_ack[c] ? 4'b0100 : 4'b0000)) begin
                $display("FAIL burst_ack c%0d: got %b want %b", c, ack, exp_ack[c] ? 4'b0100 : 4'b0000); errors++;
            end
            checks++;
            if (busy !== (c != 0 && c != 5)) begin
                $display("FAIL burst_busy c%0d: got %b want %b", c, busy, (c != 0 && c != 5)); errors++;
            end
            checks++;
            if (exp_ack[c]) begin
                if (fifo_data_in !== dword(2, k)) begin
                    $display("FAIL burst_data c%0d: got %h want %h", c, fifo_data_in, dword(2, k)); errors++;
                end
                checks++;
                k++;
            end
        end
        drain();
    endtask

    task automatic test_round_robin();
        int k [NREQ];
        int o;
        for (int i = 0; i < NREQ; i++) k[i] = 0;
        cyc();
        rst_ = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_data(i, dword(i, 0));
        #1;
        rst_ = 1'b1;
        #1;
        if (busy !== 1'b0) begin $display("FAIL rr_start_idle: busy got %b want 0", busy); errors++; end
        checks++;
        for (int g = 0; g < 5; g++) begin
            o = g % NREQ;
            for (int b = 0; b < BURST; b++) begin
                cyc();
                for (int i = 0; i < NREQ; i++) set_data(i, dword(i, k[i]));
                #1;
                if (busy !== 1'b1 || owner !== 2'(o)) begin
                    $display("FAIL rr_owner g%0d b%0d: busy=%b owner=%0d want 1/%0d", g, b, busy, owner, o); errors++;
                end
                checks++;
                if (ack !== (4'b0001 << o) || fifo_data_in !== dword(o, k[o])) begin
                    $display("FAIL rr_ack g%0d b%0d: ack=%b data=%h want %b/%h", g, b, ack, fifo_data_in,
                             4'b0001 << o, dword(o, k[o])); errors++;
                end
                checks++;
                k[o]++;
            end
            cyc();
            #1;
            if (busy !== 1'b0 || ack !== 4'b0000) begin
                $display("FAIL rr_gap g%0d: busy=%b ack=%b want 0/0000", g, busy, ack); errors++;
            end
            checks++;
        end
        req = '0;
        drain();
    endtask

    task automatic test_full_stall();
        int k;
        logic full_v [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic ack_v  [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        logic busy_v [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        k = 0;
        for (int c = 0; c < 9; c++) begin
            if (c != 0) cyc();
            req = 4'b0010;
            fifo_full = full_v[c];
            set_data(1, dword(1, k));
            #1;
            if (fifo_write !== ack_v[c] || ack !== (ack_v[c] ? 4'b0010 : 4'b0000)) begin
                $display("FAIL full_write c%0d: write=%b ack=%b want %b", c, fifo_write, ack, ack_v[c]); errors++;
            end
            checks++;
            if (busy !== busy_v[c]) begin
                $display("FAIL full_busy c%0d: got %b want %b", c, busy, busy_v[c]); errors++;
            end
            checks++;
            if (ack_v[c]) begin
                if (fifo_data_in !== dword(1, k)) begin
                    $display("FAIL full_data c%0d: got %h want %h", c, fifo_data_in, dword(1, k)); errors++;
                end
                checks++;
                k++;
            end
        end
        fifo_full = 1'b0;
        drain();
    endtask

    task automatic test_withdrawal();
        logic [3:0] req_v  [5] = '{4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001};
        logic [3:0] ack_v  [5] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
        logic       busy_v [5] = '{0, 1, 1, 0, 1};
        logic [1:0] own_v  [5] = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0};
        for (int c = 0; c < 5; c++) begin
            if (c != 0) cyc();
            req = req_v[c];
            set_data(3, dword(3, 0));
            set_data(0, dword(0, 7));
            #1;
            if (ack !== ack_v[c] || busy !== busy_v[c]) begin
                $display("FAIL wd_state c%0d: ack=%b busy=%b want %b/%b", c, ack, busy, ack_v[c], busy_v[c]); errors++;
            end
            checks++;
            if (busy_v[c] && owner !== own_v[c]) begin
                $display("FAIL wd_owner c%0d: got %0d want %0d", c, owner, own_v[c]); errors++;
            end
            checks++;
        end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b0100;
        set_data(2, dword(2, 0));
        #1;
        cyc();
        #1;
        if (ack !== 4'b0100 || owner !== 2'd2) begin
            $display("FAIL mid_first: ack=%b owner=%0d want 0100/2", ack, owner); errors++;
        end
        checks++;
        cyc();
        set_data(2, dword(2, 1));
        #1;
        if (fifo_write !== 1'b1 || fifo_data_in !== dword(2, 1)) begin
            $display("FAIL mid_second: write=%b data=%h want 1/%h", fifo_write, fifo_data_in, dword(2, 1)); errors++;
        end
        checks++;
        rst_ = 1'b0;
        req = 4'b1001;
        #1;
        if (fifo_write !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            $display("FAIL mid_async: write=%b ack=%b busy=%b owner=%0d want 0/0000/0/0",
                     fifo_write, ack, busy, owner); errors++;
        end
        checks++;
        cyc();
        rst_ = 1'b1;
        #1;
        if (busy !== 1'b0) begin $display("FAIL mid_rel_idle: busy got %b want 0", busy); errors++; end
        checks++;
        cyc();
        #1;
        if (owner !== 2'd0 || ack !== 4'b0001) begin
            $display("FAIL mid_regrant: owner=%0d ack=%b want 0/0001", owner, ack); errors++;
        end
        checks++;
        drain();
    endtask

    initial begin
        rst_      = 1'b0;
        req       = 4'b1111;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dword(i, 0);
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_withdrawal();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
